// File: rtl/pipe_pkg.sv
// pipe_pkg: forwarding encodings, default register index width and the shadow-slot type
// shared by hazard_ctrl and hazard_cmp.
package pipe_pkg;
    localparam int REG_AW = 5;
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              load;
    } slot_t;
endpackage

// File: rtl/hazard_cmp.sv
// hazard_cmp: RAW checks of one source operand against the EX/MEM/WB shadow slots.
// HAZARD_FWD_EN enables forwarding; without it any in-flight producer stalls the operand.
module hazard_cmp import pipe_pkg::*; #(
    parameter int AW = REG_AW
) (
    input  logic [AW-1:0] rs,
    input  logic          used,
    input  slot_t         ex,
    input  slot_t         mem,
    input  slot_t         wb,
    output logic          stall,
    output logic [1:0]    fwd
);
    logic live;
    logic hit_ex;
    logic hit_mem;
    logic load_use;
    logic wb_hit;
    assign live     = used && rs != '0;
    assign hit_ex   = live && ex.valid && ex.we && ex.rd == rs;
    assign hit_mem  = live && mem.valid && mem.we && mem.rd == rs;
    assign wb_hit   = live && wb.valid && wb.we && wb.rd == rs;
    assign load_use = hit_ex && ex.load;
`ifdef HAZARD_FWD_EN
    assign stall = load_use || wb_hit;
    // EX is checked first so the youngest producer wins
    assign fwd   = (hit_ex && !ex.load) ? FWD_EXMEM : hit_mem ? FWD_MEMWB : FWD_RF;
`else
    assign stall = load_use || hit_ex || hit_mem || wb_hit;
    assign fwd   = FWD_RF;
`endif
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/freeze and operand-forwarding control for the 5-stage pipeline.
// Define HAZARD_FWD_EN to forward from EX/MEM and MEM/WB; otherwise RAW hazards stall until retired.
module hazard_ctrl #(
    parameter int REG_AW  = pipe_pkg::REG_AW,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [NUM_SRC-1:0]        id_rs_used,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic                      id_we,
    input  logic                      id_is_load,
    input  logic                      ex_branch_taken,
    input  logic                      mem_ready,
    output logic                      stall_if,
    output logic                      flush_id,
    output logic                      bubble_ex,
    output logic                      freeze,
    output logic [2*NUM_SRC-1:0]      fwd_sel,
    output logic [CNT_W-1:0]          stall_cnt
);
    import pipe_pkg::*;
    slot_t                ex_s;
    slot_t                mem_s;
    slot_t                wb_s;
    slot_t                id_s;
    logic [NUM_SRC-1:0]   src_stall;
    logic [2*NUM_SRC-1:0] nxt_fwd;
    logic                 hazard;
    logic                 advance;
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        hazard_cmp #(.AW(REG_AW)) u_cmp (
            .rs   (id_rs[k*REG_AW +: REG_AW]),
            .used (id_rs_used[k]),
            .ex   (ex_s),
            .mem  (mem_s),
            .wb   (wb_s),
            .stall(src_stall[k]),
            .fwd  (nxt_fwd[2*k +: 2])
        );
    end
    // freeze masks everything; a taken branch squashes the (wrong-path) stalled ID instruction
    assign freeze    = !mem_ready;
    assign flush_id  = ex_branch_taken && !freeze;
    assign hazard    = id_valid && |src_stall && !freeze;
    assign stall_if  = hazard && !flush_id;
    assign bubble_ex = hazard || flush_id;
    assign advance   = id_valid && !bubble_ex;
    assign id_s      = {1'b1, id_rd, id_we, id_is_load};
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_s      <= '0;
            mem_s     <= '0;
            wb_s      <= '0;
            fwd_sel   <= '0;
            stall_cnt <= '0;
        end else begin
            if (!freeze) begin
                ex_s    <= advance ? id_s : '0;
                mem_s   <= ex_s;
                wb_s    <= mem_s;
                fwd_sel <= advance ? nxt_fwd : '0;
            end
            if ((stall_if || freeze) && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven check of hazard_ctrl with an expected-value scoreboard queue;
// a second instance with a 2-bit counter covers saturation.
module tb_hazard_ctrl;
    localparam int NV = 38;
    logic       clk = 1'b0;
    logic       rst, id_valid, id_we, id_is_load, ex_branch_taken, mem_ready;
    logic [9:0] id_rs;
    logic [1:0] id_rs_used;
    logic [4:0] id_rd;
    logic       stall_if, flush_id, bubble_ex, freeze;
    logic [3:0] fwd_sel;
    logic [15:0] stall_cnt;
    logic       s_stall_if, s_flush_id, s_bubble_ex, s_freeze;
    logic [3:0] s_fwd_sel;
    logic [1:0] s_stall_cnt;
    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic rst, v;
        logic [4:0] rs1, rs2;
        logic [1:0] used;
        logic [4:0] rd;
        logic we, ld, br, mr;
    } stim_t;
    typedef struct packed {
        logic [3:0]  h;
        logic [3:0]  fwd;
        logic [15:0] cnt;
    } exp_t;
    typedef struct packed {
        stim_t s;
        exp_t  e;
    } vec_t;

    vec_t  tbl [NV];
    exp_t  xp  [NV];
    exp_t  q[$];
    int    rq[$];
    exp_t  cur;
    int    cur_row;

    always #5 clk = ~clk;

    hazard_ctrl u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken),
        .mem_ready(mem_ready), .stall_if(stall_if), .flush_id(flush_id), .bubble_ex(bubble_ex),
        .freeze(freeze), .fwd_sel(fwd_sel), .stall_cnt(stall_cnt)
    );
    hazard_ctrl #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken),
        .mem_ready(mem_ready), .stall_if(s_stall_if), .flush_id(s_flush_id), .bubble_ex(s_bubble_ex),
        .freeze(s_freeze), .fwd_sel(s_fwd_sel), .stall_cnt(s_stall_cnt)
    );

    function automatic stim_t s(input bit r, v, input int a, b, u, d, input bit w, l, br, mr);
        return {r, v, 5'(a), 5'(b), 2'(u), 5'(d), w, l, br, mr};
    endfunction
    function automatic exp_t e(input logic [3:0] h, input logic [3:0] f, input int c);
        return {h, f, 16'(c)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, cur_row, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            cur     = q.pop_front();
            cur_row = rq.pop_front();
            chk("stall_if", 32'(stall_if), 32'(cur.h[3]));
            chk("flush_id", 32'(flush_id), 32'(cur.h[2]));
            chk("bubble_ex", 32'(bubble_ex), 32'(cur.h[1]));
            chk("freeze", 32'(freeze), 32'(cur.h[0]));
            chk("fwd_sel", 32'(fwd_sel), 32'(cur.fwd));
            chk("stall_cnt", 32'(stall_cnt), 32'(cur.cnt));
            chk("sat_ctrl", 32'({s_stall_if, s_flush_id, s_bubble_ex, s_freeze}), 32'(cur.h));
            chk("sat_fwd_sel", 32'(s_fwd_sel), 32'(cur.fwd));
            chk("sat_stall_cnt", 32'(s_stall_cnt), cur.cnt > 16'd3 ? 32'd3 : 32'(cur.cnt));
        end
    end

    task automatic apply(input stim_t st, input exp_t ex, input int row);
        rst             = st.rst;
        id_valid        = st.v;
        id_rs           = {st.rs2, st.rs1};
        id_rs_used      = st.used;
        id_rd           = st.rd;
        id_we           = st.we;
        id_is_load      = st.ld;
        ex_branch_taken = st.br;
        mem_ready       = st.mr;
        q.push_back(ex);
        rq.push_back(row);
        @(posedge clk);
        #1;
    endtask

    initial begin
        stim_t idle;
        int    c1;
        idle = s(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < NV; i++) tbl[i].s = idle;
        tbl[1].s  = s(0, 1, 0, 0, 1, 5, 1, 0, 0, 1);
        for (int i = 2; i <= 5; i++) tbl[i].s = s(0, 1, 5, 5, 3, 6, 1, 0, 0, 1);
        tbl[7].s  = s(0, 1, 0, 0, 1, 0, 1, 0, 0, 1);
        tbl[8].s  = s(0, 1, 0, 0, 3, 1, 1, 0, 0, 1);
        tbl[10].s = s(0, 1, 2, 0, 1, 8, 1, 1, 0, 1);
        for (int i = 11; i <= 14; i++) tbl[i].s = s(0, 1, 8, 2, 3, 9, 1, 0, 0, 1);
        tbl[16].s = s(0, 1, 0, 0, 1, 10, 1, 1, 0, 1);
        tbl[17].s = s(0, 1, 10, 10, 3, 11, 1, 0, 1, 1);
        tbl[19].s = s(0, 1, 0, 0, 1, 12, 1, 1, 0, 1);
        for (int i = 21; i <= 23; i++) tbl[i].s = s(0, 1, 12, 0, 1, 13, 1, 0, 0, 0);
        for (int i = 24; i <= 26; i++) tbl[i].s = s(0, 1, 12, 0, 1, 13, 1, 0, 0, 1);
        tbl[27].s = s(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[28].s = s(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        tbl[29].s = s(0, 1, 13, 0, 1, 14, 1, 0, 0, 0);
        tbl[30].s = s(1, 1, 13, 0, 1, 14, 1, 0, 0, 0);
        tbl[31].s = s(0, 1, 13, 0, 1, 14, 1, 0, 0, 1);
        tbl[33].s = s(0, 1, 0, 0, 1, 5, 1, 0, 0, 1);
        tbl[35].s = s(0, 1, 5, 1, 3, 7, 1, 0, 0, 1);
        tbl[36].s = s(0, 0, 5, 1, 3, 7, 1, 0, 0, 1);
`ifdef HAZARD_FWD_EN
        c1 = 0;
        xp = '{e(4'b0000, 4'h0, 0), e(4'b0000, 4'h0, 0), e(4'b0000, 4'h0, 0), e(4'b0000, 4'h5, 0),
               e(4'b1010, 4'hA, 0), e(4'b0000, 4'h0, 1), e(4'b0000, 4'h0, 1), e(4'b0000, 4'h0, 1),
               e(4'b0000, 4'h0, 1), e(4'b0000, 4'h0, 1), e(4'b0000, 4'h0, 1), e(4'b1010, 4'h0, 1),
               e(4'b0000, 4'h0, 2), e(4'b1010, 4'h2, 2), e(4'b0000, 4'h0, 3), e(4'b0000, 4'h0, 3),
               e(4'b0000, 4'h0, 3), e(4'b0110, 4'h0, 3), e(4'b0000, 4'h0, 3), e(4'b0000, 4'h0, 3),
               e(4'b0000, 4'h0, 3), e(4'b0001, 4'h0, 3), e(4'b0001, 4'h0, 4), e(4'b0001, 4'h0, 5),
               e(4'b0000, 4'h0, 6), e(4'b1010, 4'h2, 6), e(4'b0000, 4'h0, 7), e(4'b0001, 4'h0, 7),
               e(4'b0110, 4'h0, 8), e(4'b0001, 4'h0, 8), e(4'b0001, 4'h0, 9), e(4'b0000, 4'h0, 0),
               e(4'b0000, 4'h0, 0), e(4'b0000, 4'h0, 0), e(4'b0000, 4'h0, 0), e(4'b0000, 4'h0, 0),
               e(4'b0000, 4'h2, 0), e(4'b0000, 4'h0, 0)};
`else
        c1 = 1;
        xp = '{e(4'b0000, 4'h0, 0), e(4'b0000, 4'h0, 0), e(4'b1010, 4'h0, 0), e(4'b1010, 4'h0, 1),
               e(4'b1010, 4'h0, 2), e(4'b0000, 4'h0, 3), e(4'b0000, 4'h0, 3), e(4'b0000, 4'h0, 3),
               e(4'b0000, 4'h0, 3), e(4'b0000, 4'h0, 3), e(4'b0000, 4'h0, 3), e(4'b1010, 4'h0, 3),
               e(4'b1010, 4'h0, 4), e(4'b1010, 4'h0, 5), e(4'b0000, 4'h0, 6), e(4'b0000, 4'h0, 6),
               e(4'b0000, 4'h0, 6), e(4'b0110, 4'h0, 6), e(4'b0000, 4'h0, 6), e(4'b0000, 4'h0, 6),
               e(4'b0000, 4'h0, 6), e(4'b0001, 4'h0, 6), e(4'b0001, 4'h0, 7), e(4'b0001, 4'h0, 8),
               e(4'b1010, 4'h0, 9), e(4'b1010, 4'h0, 10), e(4'b0000, 4'h0, 11), e(4'b0001, 4'h0, 11),
               e(4'b0110, 4'h0, 12), e(4'b0001, 4'h0, 12), e(4'b0001, 4'h0, 13), e(4'b0000, 4'h0, 0),
               e(4'b0000, 4'h0, 0), e(4'b0000, 4'h0, 0), e(4'b0000, 4'h0, 0), e(4'b1010, 4'h0, 0),
               e(4'b0000, 4'h0, 1), e(4'b0000, 4'h0, 1)};
`endif
        for (int i = 0; i < NV; i++) tbl[i].e = xp[i];
        rst = 1'b1;
        id_valid = 1'b0;
        id_rs = '0;
        id_rs_used = '0;
        id_rd = '0;
        id_we = 1'b0;
        id_is_load = 1'b0;
        ex_branch_taken = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NV; i++) apply(tbl[i].s, tbl[i].e, i);
        // reset while a load-use stall is being asserted
        apply(s(0, 1, 0, 0, 1, 3, 1, 1, 0, 1), e(4'b0000, 4'h0, c1), 100);
        apply(s(1, 1, 3, 0, 1, 4, 1, 0, 0, 1), e(4'b1010, 4'h0, c1), 101);
        apply(s(0, 1, 3, 0, 1, 4, 1, 0, 0, 1), e(4'b0000, 4'h0, 0), 102);
        apply(idle, e(4'b0000, 4'h0, 0), 103);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
